// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch/sequencer: fetches one word per instruction,
// holds it in the instruction register and computes the next PC on retire.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               nrst,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        instr_o,
  output logic [5:0]         opcode_o,
  output logic               instr_valid_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  input  logic               retire_i,
  input  logic               branch_i,
  input  logic               mux_branch_jump_i,
  input  logic               mux_pc_branch_i,
  input  logic               alu_zero_i,
  output logic [31:0]        retired_cnt_o,
  output logic               fetch_err_o
);

  localparam logic [31:0] RESET_PC_AL  = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 32'd1);
  localparam bit          TIMEOUT_EN   = (ACK_TIMEOUT != 32'd0);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    ERR   = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] instr_q;
  logic [31:0] retired_cnt_q;
  logic [31:0] wait_cnt_q;
  logic        req_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] br_target_d;
  logic [31:0] next_pc_d;

  // Next-PC selection; jump has priority over both branch flavours.
  always_comb begin
    br_target_d = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (!mux_pc_branch_i && !mux_branch_jump_i) begin
      next_pc_d = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end else if (branch_i && alu_zero_i) begin
      next_pc_d = br_target_d;
    end else if (mux_pc_branch_i && !mux_branch_jump_i && !alu_zero_i) begin
      next_pc_d = br_target_d;
    end else begin
      next_pc_d = pc_plus4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= START;
      pc_q          <= RESET_PC_AL;
      pc_plus4_q    <= RESET_PC_AL + 32'd4;
      instr_q       <= 32'd0;
      retired_cnt_q <= 32'd0;
      wait_cnt_q    <= 32'd0;
      req_q         <= 1'b0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            instr_q    <= imem.imem_rdata;
            wait_cnt_q <= 32'd0;
            req_q      <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= ISSUE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
            if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST)) begin
              req_q   <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        ISSUE: begin
          if (retire_i) begin
            pc_q          <= next_pc_d;
            pc_plus4_q    <= next_pc_d + 32'd4;
            retired_cnt_q <= retired_cnt_q + 32'd1;
            valid_q       <= 1'b0;
            req_q         <= 1'b1;
            state_q       <= FETCH;
          end else begin
            state_q <= ISSUE;
          end
        end
        ERR: begin
          // Terminal until reset; PC and instruction register stay frozen.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
          state_q <= ERR;
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= START;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign opcode_o       = instr_q[31:26];
  assign instr_valid_o  = valid_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4_q;
  assign retired_cnt_o  = retired_cnt_q;
  assign fetch_err_o    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_instr_fetch_unit;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, retire, branch, mbj, mpb, zero;
  logic [31:0] instr, pc, pc4, cnt;
  logic [5:0]  opc;
  logic        valid, err;

  logic        nrst2, retire2;
  logic [31:0] instr2, pc2, pc42, cnt2;
  logic [5:0]  opc2;
  logic        valid2, err2;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .imem(bus),
    .instr_o(instr), .opcode_o(opc), .instr_valid_o(valid), .pc_o(pc), .pc_plus4_o(pc4),
    .retire_i(retire), .branch_i(branch), .mux_branch_jump_i(mbj), .mux_pc_branch_i(mpb),
    .alu_zero_i(zero), .retired_cnt_o(cnt), .fetch_err_o(err)
  );

  // Misaligned reset PC and disabled timeout exercise the parameter paths.
  instr_fetch_unit #(.RESET_PC(32'h4000_000B), .ACK_TIMEOUT(0)) dut2 (
    .clk(clk), .nrst(nrst2), .imem(bus2),
    .instr_o(instr2), .opcode_o(opc2), .instr_valid_o(valid2), .pc_o(pc2), .pc_plus4_o(pc42),
    .retire_i(retire2), .branch_i(branch), .mux_branch_jump_i(mbj), .mux_pc_branch_i(mpb),
    .alu_zero_i(zero), .retired_cnt_o(cnt2), .fetch_err_o(err2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m_pc, m_instr, m_cnt;
  int          m_wait;
  logic        m_req, m_valid, m_err, m_start;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic b, input logic jb, input logic pb,
                                             input logic z);
    logic [31:0] p4;
    longint      off;
    p4  = cur + 32'd4;
    off = longint'($signed(ins[15:0])) * 64'sd4;
    if (!pb && !jb) return (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    if ((b && z) || (pb && !jb && !z)) return 32'(longint'(p4) + off);
    return p4;
  endfunction

  task automatic model_step();
    if (!nrst) begin
      m_pc = 32'd0; m_instr = 32'd0; m_cnt = 32'd0; m_wait = 0;
      m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_start = 1'b1;
    end else if (m_start) begin
      m_start = 1'b0;
      m_req   = 1'b1;
    end else if (!m_err) begin
      if (m_req) begin
        if (bus.imem_ack) begin
          m_instr = bus.imem_rdata; m_req = 1'b0; m_valid = 1'b1; m_wait = 0;
        end else begin
          if (m_wait == TO - 1) begin
            m_err = 1'b1; m_req = 1'b0;
          end
          m_wait++;
        end
      end else if (m_valid && retire) begin
        m_pc    = model_next(m_pc, m_instr, branch, mbj, mpb, zero);
        m_cnt   = m_cnt + 32'd1;
        m_valid = 1'b0;
        m_req   = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Cycle-by-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req", 32'(bus.imem_req), 32'(m_req));
      check("imem_addr", bus.imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("pc_plus4", pc4, m_pc + 32'd4);
      check("instr", instr, m_instr);
      check("opcode", 32'(opc), 32'(m_instr[31:26]));
      check("instr_valid", 32'(valid), 32'(m_valid));
      check("retired_cnt", cnt, m_cnt);
      check("fetch_err", 32'(err), 32'(m_err));
    end
  end

  // Fetch one word after wt wait cycles and retire it with the given controls.
  task automatic do_instr(input logic [31:0] w, input logic b, input logic jb, input logic pb,
                          input logic z, input int wt);
    int guard;
    guard = 0;
    while (!m_req && guard < 50) begin
      tick();
      guard++;
    end
    repeat (wt) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = w;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = $urandom;
    branch = b; mbj = jb; mpb = pb; zero = z; retire = 1'b1;
    tick();
    retire = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; retire = 1'b0; branch = 1'b0; mbj = 1'b1; mpb = 1'b0; zero = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
    nrst2 = 1'b0; retire2 = 1'b0; bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'd0;
    tick();
    cmp_en = 1'b1;

    // Second instance: aligned reset PC, jump inside upper region, no timeout.
    tick();
    check("d2_reset_pc", pc2, 32'h4000_0008);
    check("d2_reset_addr", bus2.imem_addr, 32'h4000_0008);
    nrst2 = 1'b1;
    tick();
    check("d2_req", 32'(bus2.imem_req), 32'd1);
    bus2.imem_ack = 1'b1; bus2.imem_rdata = {6'h02, 26'h000_0100};
    tick();
    bus2.imem_ack = 1'b0;
    mpb = 1'b0; mbj = 1'b0; branch = 1'b0; retire2 = 1'b1;
    tick();
    retire2 = 1'b0; mbj = 1'b1;
    check("d2_jump_pc", pc2, 32'h4000_0400);
    repeat (40) tick();
    check("d2_no_timeout_err", 32'(err2), 32'd0);
    check("d2_no_timeout_req", 32'(bus2.imem_req), 32'd1);

    // Main instance: reset values, START cycle, zero-wait fetch of an addi.
    check("reset_pc", pc, 32'h0);
    check("reset_req", 32'(bus.imem_req), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_instr", instr, 32'h0);
    check("reset_cnt", cnt, 32'h0);
    nrst = 1'b1;
    tick();
    check("req_after_start", 32'(bus.imem_req), 32'd1);
    check("addr_first", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2008_0005;
    tick();
    bus.imem_ack = 1'b0;
    check("valid_n1", 32'(valid), 32'd1);
    check("instr_addi", instr, 32'h2008_0005);
    check("opcode_addi", 32'(opc), 32'h08);
    check("req_low_issue", 32'(bus.imem_req), 32'd0);
    branch = 1'b0; mbj = 1'b1; mpb = 1'b0; retire = 1'b1;
    tick();
    retire = 1'b0;
    check("pc_after_addi", pc, 32'h4);
    check("cnt_after_addi", cnt, 32'd1);
    check("req_m1", 32'(bus.imem_req), 32'd1);
    check("addr_m1", bus.imem_addr, 32'h4);

    // beq / bne targets from hand-placed PCs.
    do_instr({6'h02, 26'd4}, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    check("jump_to_10", pc, 32'h10);
    do_instr({6'h04, 10'd0, 16'hFFFC}, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("beq_taken", pc, 32'h04);
    do_instr({6'h02, 26'd4}, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    do_instr({6'h04, 10'd0, 16'hFFFC}, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    check("beq_not_taken", pc, 32'h14);
    do_instr({6'h02, 26'd8}, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("jump_to_20", pc, 32'h20);
    do_instr({6'h05, 10'd0, 16'h0003}, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("bne_taken", pc, 32'h30);
    do_instr({6'h02, 26'd8}, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_instr({6'h05, 10'd0, 16'h0003}, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("bne_not_taken", pc, 32'h24);

    // Backward branch from 0 wraps to the top of memory, then wraps back.
    do_instr({6'h02, 26'd0}, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_instr({6'h04, 10'd0, 16'hFFFE}, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    check("pc_top", pc, 32'hFFFF_FFFC);
    check("pc4_wrap", pc4, 32'h0);
    do_instr(32'h2008_0005, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("pc_wrap", pc, 32'h0);
    check("cnt_directed", cnt, 32'd12);

    // Ack timeout: 15 silent cycles are fine, the 16th raises the error.
    repeat (15) tick();
    check("no_err_15", 32'(err), 32'd0);
    tick();
    check("err_16", 32'(err), 32'd1);
    check("req_err", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
    tick();
    bus.imem_ack = 1'b0;
    check("ack_ignored_err", instr, 32'h2008_0005);
    check("valid_err", 32'(valid), 32'd0);
    nrst = 1'b0;
    tick();
    check("err_cleared", 32'(err), 32'd0);

    // Reset during a fetch wait discards a same-cycle ack.
    nrst = 1'b1;
    tick();
    repeat (2) tick();
    nrst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0; nrst = 1'b1;
    check("rst_fetch_req", 32'(bus.imem_req), 32'd0);
    check("rst_fetch_instr", instr, 32'h0);
    check("rst_fetch_pc", pc, 32'h0);
    tick();
    check("restart_req", 32'(bus.imem_req), 32'd1);

    // Random traffic: stray acks/retires, simultaneous ack+retire, rare resets.
    for (int i = 0; i < 4000; i++) begin
      nrst          = ($urandom_range(0, 199) != 0);
      bus.imem_ack  = ($urandom_range(0, 99) < 35);
      bus.imem_rdata = $urandom;
      retire        = ($urandom_range(0, 99) < 40);
      branch        = $urandom_range(0, 1);
      mbj           = $urandom_range(0, 1);
      mpb           = $urandom_range(0, 1);
      zero          = $urandom_range(0, 1);
      tick();
    end
    nrst = 1'b1; bus.imem_ack = 1'b0; retire = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
